// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Instructions are word aligned; the low address bits carry no meaning.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, branch logic and decoder.
// master = fetch unit side, slave = environment (memory/decoder/branch unit).
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit_chk.sv
// Simulation-time protocol checks for the fetch unit (memory responses and queue credit).
module instr_fetch_unit_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rsp_valid,
    input logic [CW-1:0] outstanding,
    input logic          push,
    input logic          full
);
    // A response with nothing outstanding is a memory protocol error; pushes never hit a full queue.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(rsp_valid && (outstanding == '0)))
                else $error("instr_fetch_unit: response with no outstanding request");
            assert (!(push && full))
                else $error("instr_fetch_unit: prefetch queue overflow");
        end
    end
endmodule

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests: pop only when data exists, push only when space exists (or freed now).
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != FULL_COUNT) || do_pop_s);
    end

    // Pointer and occupancy tracking; flush discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            if (do_push_s && !do_pop_s)      count_r <= count_r + 1'b1;
            else if (!do_push_s && do_pop_s) count_r <= count_r - 1'b1;
            else                             count_r <= count_r;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == '0);
    assign full  = (count_r == FULL_COUNT);
    assign count = count_r;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, credit-limited memory fetches,
// prefetch queue toward the decoder, redirect with flush and in-flight discard.
// Optional feature macro: IFU_PERF_CNT_EN adds perf_fetched/perf_stall counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall
`endif
);
    localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(QUEUE_DEPTH);

    ifu_state_e    state_r, state_s;
    logic [31:0]   fetch_pc_r, fetch_pc_s;
    logic [31:0]   rsp_pc_r, rsp_pc_s;
    logic [CW-1:0] outstanding_r, outstanding_s;
    logic [CW-1:0] discard_r, discard_s;
    logic [CW-1:0] q_count_s;
    logic [CW:0]   inflight_s;
    logic          req_valid_s, req_fire_s;
    logic          rsp_ok_s, rsp_drop_s;
    logic          push_s, pop_s, flush_s;
    logic          q_empty_s, q_full_s;
    fetch_entry_t  push_entry_s, head_s;

    // Next-state, request credit, response accounting and redirect handling.
    always_comb begin
        state_s       = state_r;
        fetch_pc_s    = fetch_pc_r;
        rsp_pc_s      = rsp_pc_r;
        outstanding_s = outstanding_r;
        discard_s     = discard_r;
        flush_s       = 1'b0;
        inflight_s    = {1'b0, outstanding_r} + {1'b0, q_count_s};
        rsp_ok_s      = bus.imem_rsp_valid && (outstanding_r != '0);
        // A response landing with a redirect belongs to the old stream.
        rsp_drop_s    = rsp_ok_s && (bus.redirect_valid || (state_r == DRAIN));
        push_s        = rsp_ok_s && !rsp_drop_s;
        push_entry_s  = '{pc: rsp_pc_r, instr: bus.imem_rsp_data};

        if ((state_r == RUN) && !bus.redirect_valid && (inflight_s < CREDITS)) req_valid_s = 1'b1;
        else                                                                     req_valid_s = 1'b0;
        req_fire_s = req_valid_s && bus.imem_req_ready;

        if (req_fire_s) fetch_pc_s = fetch_pc_r + INSTR_BYTES;
        else            fetch_pc_s = fetch_pc_r;
        if (push_s)     rsp_pc_s = rsp_pc_r + INSTR_BYTES;
        else            rsp_pc_s = rsp_pc_r;

        case ({req_fire_s, rsp_ok_s})
            2'b10:   outstanding_s = outstanding_r + 1'b1;
            2'b01:   outstanding_s = outstanding_r - 1'b1;
            default: outstanding_s = outstanding_r;
        endcase

        case (state_r)
            BOOT:    state_s = RUN;
            RUN:     state_s = RUN;
            DRAIN: begin
                if (rsp_drop_s && (discard_r != '0)) discard_s = discard_r - 1'b1;
                else                                  discard_s = discard_r;
                if (discard_s == '0) state_s = RUN;
                else                 state_s = DRAIN;
            end
            default: state_s = BOOT;
        endcase

        // Every accepted request still in flight now belongs to the abandoned stream.
        if (bus.redirect_valid) begin
            flush_s    = 1'b1;
            fetch_pc_s = align_pc(bus.redirect_pc);
            rsp_pc_s   = align_pc(bus.redirect_pc);
            discard_s  = outstanding_s;
            if ((state_r == DRAIN) || (outstanding_s != '0)) state_s = DRAIN;
            else                                              state_s = RUN;
        end else begin
            flush_s = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= BOOT;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= '0;
            discard_r     <= '0;
        end else begin
            state_r       <= state_s;
            fetch_pc_r    <= fetch_pc_s;
            rsp_pc_r      <= rsp_pc_s;
            outstanding_r <= outstanding_s;
            discard_r     <= discard_s;
        end
    end

    assign pop_s = bus.instr_ready && !q_empty_s;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   (push_entry_s),
        .dout  (head_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

    instr_fetch_unit_chk #(.CW(CW)) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .rsp_valid   (bus.imem_rsp_valid),
        .outstanding (outstanding_r),
        .push        (push_s),
        .full        (q_full_s)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.instr_valid    = !q_empty_s;
    assign bus.instr_data     = q_empty_s ? NOP_INSTR : head_s.instr;
    assign bus.instr_pc       = q_empty_s ? 32'h0000_0000 : head_s.pc;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;

    // Delivered-instruction and decoder-starvation counters; survive redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r <= 32'd0;
            perf_stall_r   <= 32'd0;
        end else begin
            if (pop_s)                         perf_fetched_r <= perf_fetched_r + 32'd1;
            if (bus.instr_ready && q_empty_s)  perf_stall_r   <= perf_stall_r + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then randomized traffic, with an
// in-bench memory and a stream model (expected PC sequence plus redirect targets).
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    instr_fetch_unit_if bus();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       rsp_q[$];
    int          total   = 0;
    int          bad     = 0;
    int          cyc     = 0;
    int          n_hs    = 0;
    int          n_req   = 0;
    int          n_stall = 0;
    int          mem_lat = 1;
    logic [31:0] exp_pc       = 32'h0;
    logic [31:0] exp_req_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive memory response, observe handshakes, update the stream model.
    task automatic tick();
        pend_t p;
        logic  fire;
        logic  hs;
        if ((rsp_q.size() > 0) && (rsp_q[0].due <= cyc)) begin
            p = rsp_q.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(p.addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        fire = bus.imem_req_valid && bus.imem_req_ready;
        hs   = bus.instr_valid && bus.instr_ready;
        if (bus.redirect_valid) check("no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
        if (fire) begin
            check("req_addr", bus.imem_req_addr, exp_req_addr);
            p.addr = bus.imem_req_addr;
            p.due  = cyc + mem_lat;
            rsp_q.push_back(p);
            exp_req_addr = exp_req_addr + 32'd4;
            n_req++;
        end
        check("credit_bound", 32'(rsp_q.size() <= DEPTH), 32'd1);
        if (hs) begin
            check("instr_pc", bus.instr_pc, exp_pc);
            check("instr_data", bus.instr_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_hs++;
        end
        if (bus.instr_ready && !bus.instr_valid) n_stall++;
        if (bus.redirect_valid) begin
            exp_pc       = {bus.redirect_pc[31:2], 2'b00};
            exp_req_addr = {bus.redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        bus.redirect_valid = 1'b0;
    endtask

    // Asynchronous reset pulse placed mid-cycle; reset values must appear without a clock edge.
    task automatic do_reset();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr_data", bus.instr_data, 32'h0000_0013);
        check("rst_instr_pc", bus.instr_pc, 32'h0000_0000);
`ifdef IFU_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
        rsp_q.delete();
        exp_pc       = 32'h0;
        exp_req_addr = 32'h0;
        n_hs         = 0;
        n_req        = 0;
        n_stall      = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;

        // Streaming with 1-cycle memory: three fill cycles, then one instruction per cycle.
        bus.instr_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        mem_lat            = 1;
        do_reset();
        repeat (3) tick();
        check("t1_fill_no_hs", 32'(n_hs), 32'd0);
        repeat (10) tick();
        check("t1_stream_rate", 32'(n_hs), 32'd10);
`ifdef IFU_PERF_CNT_EN
        check("t6_perf_fetched", perf_fetched, 32'd10);
        check("t6_perf_stall", perf_stall, 32'd3);
`endif

        // Decoder backpressure: exactly four requests, then fetch stops until the queue drains.
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("t2_req_count", 32'(n_req), 32'd4);
        check("t2_req_blocked", 32'(bus.imem_req_valid), 32'd0);
        check("t2_head_valid", 32'(bus.instr_valid), 32'd1);
        bus.instr_ready = 1'b1;
        repeat (8) tick();
        check("t2_drained", 32'(n_hs >= 4), 32'd1);

        // Memory not ready: address held at reset PC, nothing counted as issued.
        bus.imem_req_ready = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_addr_hold", bus.imem_req_addr, 32'h0000_0000);
            check("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
            tick();
        end
        check("t3_no_issue", 32'(n_req), 32'd0);
        bus.imem_req_ready = 1'b1;
        repeat (5) tick();
        check("t3_resume", 32'(n_hs >= 1), 32'd1);

        // Redirect to an unaligned target with two fetches in flight.
        bus.instr_ready = 1'b0;
        mem_lat         = 4;
        do_reset();
        repeat (3) tick();
        check("t4_two_outstanding", 32'(rsp_q.size()), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t4_drain_no_req", 32'(bus.imem_req_valid), 32'd0);
            check("t4_drain_empty", 32'(bus.instr_valid), 32'd0);
            tick();
        end
        mem_lat         = 1;
        bus.instr_ready = 1'b1;
        repeat (8) tick();
        check("t4_new_stream", 32'(n_hs >= 1), 32'd1);

        // Redirect together with a decoder handshake and a response, then reset while draining.
        bus.instr_ready = 1'b0;
        mem_lat         = 3;
        do_reset();
        repeat (5) tick();
        check("t5_head_valid", 32'(bus.instr_valid), 32'd1);
        check("t5_rsps_pending", 32'(rsp_q.size()), 32'd3);
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        tick();
        check("t5_hs_once", 32'(n_hs), 32'd1);
        check("t5_queue_flushed", 32'(bus.instr_valid), 32'd0);
        check("t5_retarget", bus.imem_req_addr, 32'h0000_0200);
        check("t5_drain_no_req", 32'(bus.imem_req_valid), 32'd0);
        do_reset();

        // Randomized traffic: ready throttling, variable latency, random and wrapping redirects.
        for (int i = 0; i < 600; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.instr_ready    = ($urandom_range(0, 3) != 0);
            mem_lat            = int'($urandom_range(1, 3));
            if (i == 100) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'hFFFF_FFF9;
            end else if ($urandom_range(0, 19) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom;
            end else begin
                bus.redirect_valid = 1'b0;
            end
            tick();
        end
        check("rand_progress", 32'(n_hs > 100), 32'd1);
`ifdef IFU_PERF_CNT_EN
        check("rand_perf_fetched", perf_fetched, 32'(n_hs));
        check("rand_perf_stall", perf_stall, 32'(n_stall));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
